// File: rtl/utf8_pkg.sv
// Shared types and constants for the streaming UTF-8 decoder.
package utf8_pkg;

  // Decoder FSM: waiting for a lead byte, or collecting continuation bytes.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONT = 1'b1
  } state_t;

  // Replacement character emitted for malformed input.
  localparam logic [20:0] REPL_CP_DEF = 21'h00FFFD;

  // Byte order mark, dropped at stream start when BOM stripping is built in.
  localparam logic [20:0] BOM_CP = 21'h00FEFF;

  // Classification of a candidate lead byte.
  //   len     : total sequence length in bytes (1..4)
  //   payload : code point bits carried by the lead byte
  //   lo/hi   : inclusive bounds for the second byte of the sequence
  //   bad     : byte can never start a legal sequence
  typedef struct packed {
    logic [2:0] len;
    logic [6:0] payload;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       bad;
  } lead_class_t;

endpackage

// File: rtl/utf8_lead_classify.sv
// Combinational lead-byte classifier: length, payload bits, second-byte
// bounds (which exclude overlongs, surrogates and values above U+10FFFF)
// and an invalid flag.
import utf8_pkg::*;

module utf8_lead_classify (
  input  logic [7:0]  in_data,
  output lead_class_t lead_class
);

  // Decode the lead byte range into a sequence class.
  always_comb begin
    lead_class.len     = 3'd1;
    lead_class.payload = 7'd0;
    lead_class.lo      = 8'h80;
    lead_class.hi      = 8'hBF;
    lead_class.bad     = 1'b0;
    if (in_data <= 8'h7F) begin
      lead_class.payload = in_data[6:0];
    end else if ((in_data >= 8'hC2) && (in_data <= 8'hDF)) begin
      lead_class.len     = 3'd2;
      lead_class.payload = {2'b00, in_data[4:0]};
    end else if ((in_data >= 8'hE0) && (in_data <= 8'hEF)) begin
      lead_class.len     = 3'd3;
      lead_class.payload = {3'b000, in_data[3:0]};
      if (in_data == 8'hE0) begin
        lead_class.lo = 8'hA0;       // reject 3-byte overlongs
      end else if (in_data == 8'hED) begin
        lead_class.hi = 8'h9F;       // reject surrogates D800..DFFF
      end else begin
        lead_class.lo = 8'h80;
      end
    end else if ((in_data >= 8'hF0) && (in_data <= 8'hF4)) begin
      lead_class.len     = 3'd4;
      lead_class.payload = {4'b0000, in_data[2:0]};
      if (in_data == 8'hF0) begin
        lead_class.lo = 8'h90;       // reject 4-byte overlongs
      end else if (in_data == 8'hF4) begin
        lead_class.hi = 8'h8F;       // cap at U+10FFFF
      end else begin
        lead_class.lo = 8'h80;
      end
    end else begin
      // 80-BF stray continuation, C0/C1 overlong leads, F5-FF out of range
      lead_class.bad = 1'b1;
    end
  end

endmodule

// File: rtl/utf8_decoder.sv
// Streaming UTF-8 decoder: one byte in per cycle, one code point out per
// completed sequence. Malformed input produces REPL_CP with out_err set.
// Optional feature macro: UTF8_BOM_STRIP_EN drops a leading U+FEFF after
// reset or an in_sof byte.
import utf8_pkg::*;

module utf8_decoder #(
  parameter int          ERR_CNT_W = 8,
  parameter logic [20:0] REPL_CP   = REPL_CP_DEF
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_data,
  input  logic                 in_sof,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [20:0]          out_cp,
  output logic                 out_err,
  output logic [2:0]           out_len,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);

  state_t                 state_r;
  logic [1:0]             need_r;
  logic [20:0]            cp_r;
  logic [2:0]             cnt_r;
  logic [7:0]             lo_r;
  logic [7:0]             hi_r;
  logic                   out_valid_r;
  logic [20:0]            out_cp_r;
  logic                   out_err_r;
  logic [2:0]             out_len_r;
  logic [ERR_CNT_W-1:0]   err_count_r;

  lead_class_t            lc_s;
  logic                   acc_s;
  logic                   cont_ok_s;
  logic                   reject_s;
  logic                   take_s;
  state_t                 state_nxt_s;
  logic [1:0]             need_nxt_s;
  logic [20:0]            cp_nxt_s;
  logic [2:0]             cnt_nxt_s;
  logic [7:0]             lo_nxt_s;
  logic [7:0]             hi_nxt_s;
  logic                   emit_s;
  logic [20:0]            emit_cp_s;
  logic                   emit_err_s;
  logic [2:0]             emit_len_s;
  logic [1:0]             err_inc_s;
  logic [ERR_CNT_W:0]     err_sum_s;
  logic [ERR_CNT_W-1:0]   err_count_nxt_s;
  logic                   bom_drop_s;
  logic                   emit_keep_s;

  utf8_lead_classify u_lead_classify (
    .in_data    (in_data),
    .lead_class (lc_s)
  );

  // The output register can take a new code point when empty or draining.
  assign acc_s     = ~out_valid_r | out_ready;
  // In CONT the stored bounds already restrict the byte to 10xxxxxx.
  assign cont_ok_s = (in_data >= lo_r) && (in_data <= hi_r);
  // A bad continuation is left on the input and re-decoded as a lead.
  assign reject_s  = (state_r == CONT) && in_valid && !in_sof && !cont_ok_s;
  assign in_ready  = acc_s & ~reject_s;
  assign take_s    = in_valid & in_ready;

  // Next-state and emission decode for the current byte.
  always_comb begin
    state_nxt_s = state_r;
    need_nxt_s  = need_r;
    cp_nxt_s    = cp_r;
    cnt_nxt_s   = cnt_r;
    lo_nxt_s    = lo_r;
    hi_nxt_s    = hi_r;
    emit_s      = 1'b0;
    emit_cp_s   = 21'd0;
    emit_err_s  = 1'b0;
    emit_len_s  = 3'd0;
    err_inc_s   = 2'd0;
    if (acc_s && reject_s) begin
      // Truncated sequence: report what was consumed, byte stays pending.
      emit_s      = 1'b1;
      emit_cp_s   = REPL_CP;
      emit_err_s  = 1'b1;
      emit_len_s  = cnt_r;
      err_inc_s   = 2'd1;
      state_nxt_s = IDLE;
    end else if (take_s) begin
      if ((state_r == CONT) && !in_sof) begin
        // Accepted continuation byte.
        cp_nxt_s  = {cp_r[14:0], in_data[5:0]};
        cnt_nxt_s = cnt_r + 3'd1;
        lo_nxt_s  = 8'h80;
        hi_nxt_s  = 8'hBF;
        if (need_r == 2'd1) begin
          emit_s      = 1'b1;
          emit_cp_s   = {cp_r[14:0], in_data[5:0]};
          emit_len_s  = cnt_r + 3'd1;
          state_nxt_s = IDLE;
        end else begin
          need_nxt_s = need_r - 2'd1;
        end
      end else begin
        // Lead byte; a stream restart mid-sequence drops the partial.
        if (state_r == CONT) begin
          err_inc_s = 2'd1;
        end else begin
          err_inc_s = 2'd0;
        end
        state_nxt_s = IDLE;
        if (lc_s.bad) begin
          emit_s     = 1'b1;
          emit_cp_s  = REPL_CP;
          emit_err_s = 1'b1;
          emit_len_s = 3'd1;
          err_inc_s  = err_inc_s + 2'd1;
        end else if (lc_s.len == 3'd1) begin
          emit_s     = 1'b1;
          emit_cp_s  = {14'd0, lc_s.payload};
          emit_len_s = 3'd1;
        end else begin
          state_nxt_s = CONT;
          cp_nxt_s    = {14'd0, lc_s.payload};
          cnt_nxt_s   = 3'd1;
          lo_nxt_s    = lc_s.lo;
          hi_nxt_s    = lc_s.hi;
          case (lc_s.len)
            3'd2:    need_nxt_s = 2'd1;
            3'd3:    need_nxt_s = 2'd2;
            3'd4:    need_nxt_s = 2'd3;
            default: need_nxt_s = 2'd1;
          endcase
        end
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Saturating malformed-event counter; two events can land in one cycle.
  always_comb begin
    err_sum_s = {1'b0, err_count_r} + {{(ERR_CNT_W-1){1'b0}}, err_inc_s};
    if (err_sum_s[ERR_CNT_W]) begin
      err_count_nxt_s = {ERR_CNT_W{1'b1}};
    end else begin
      err_count_nxt_s = err_sum_s[ERR_CNT_W-1:0];
    end
  end

`ifdef UTF8_BOM_STRIP_EN
  logic first_r;
  logic first_nxt_s;

  // Track whether the next emitted code point is the first of its stream.
  always_comb begin
    first_nxt_s = first_r;
    bom_drop_s  = 1'b0;
    if (take_s && in_sof) begin
      first_nxt_s = 1'b1;
    end else begin
      first_nxt_s = first_r;
    end
    if (emit_s) begin
      bom_drop_s  = first_nxt_s & ~emit_err_s & (emit_cp_s == BOM_CP);
      first_nxt_s = 1'b0;
    end else begin
      bom_drop_s = 1'b0;
    end
  end
`else
  assign bom_drop_s = 1'b0;
`endif

  assign emit_keep_s = emit_s & ~bom_drop_s;

  // Decoder FSM with the registered output stage and error counter.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      need_r      <= 2'd0;
      cp_r        <= 21'd0;
      cnt_r       <= 3'd0;
      lo_r        <= 8'h80;
      hi_r        <= 8'hBF;
      out_valid_r <= 1'b0;
      out_cp_r    <= 21'd0;
      out_err_r   <= 1'b0;
      out_len_r   <= 3'd0;
      err_count_r <= {ERR_CNT_W{1'b0}};
`ifdef UTF8_BOM_STRIP_EN
      first_r     <= 1'b1;
`endif
    end else begin
      state_r     <= state_nxt_s;
      need_r      <= need_nxt_s;
      cp_r        <= cp_nxt_s;
      cnt_r       <= cnt_nxt_s;
      lo_r        <= lo_nxt_s;
      hi_r        <= hi_nxt_s;
      err_count_r <= err_count_nxt_s;
`ifdef UTF8_BOM_STRIP_EN
      first_r     <= first_nxt_s;
`endif
      if (emit_keep_s) begin
        out_valid_r <= 1'b1;
        out_cp_r    <= emit_cp_s;
        out_err_r   <= emit_err_s;
        out_len_r   <= emit_len_s;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_cp    = out_cp_r;
  assign out_err   = out_err_r;
  assign out_len   = out_len_r;
  assign busy      = (state_r == CONT);
  assign err_count = err_count_r;

endmodule

// File: tb/tb_utf8_decoder.sv
// Directed testbench for utf8_decoder with hand-computed expected code points.
module tb_utf8_decoder;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_sof;
  logic        out_valid;
  logic        out_ready;
  logic [20:0] out_cp;
  logic        out_err;
  logic [2:0]  out_len;
  logic        busy;
  logic [7:0]  err_count;

  int tests_run = 0;
  int tests_failed = 0;

  // Observed transfers packed as {err, len, cp}.
  logic [24:0] obs_q[$];

  utf8_decoder #(.ERR_CNT_W(8), .REPL_CP(21'h00FFFD)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cp    (out_cp),
    .out_err   (out_err),
    .out_len   (out_len),
    .busy      (busy),
    .err_count (err_count)
  );

  always #5 clock = ~clock;

  // Record each output transfer; inputs only change just after posedge.
  always @(negedge clock) begin
    if (rst_n && out_valid && out_ready) begin
      obs_q.push_back({out_err, out_len, out_cp});
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Present one byte and hold it until accepted (bounded wait).
  task automatic send_byte(input logic [7:0] b, input logic sof);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    in_sof   = sof;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clock);
      #1;
    end
    check_eq("send_accept", {31'd0, ok}, 32'd1);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // Pop the next observed code point and compare all fields.
  task automatic expect_cp(input string tag, input logic [20:0] cp, input logic err, input logic [2:0] len);
    logic [24:0] e;
    int n;
    n = 0;
    while ((obs_q.size() == 0) && (n < 50)) begin
      @(posedge clock);
      n++;
    end
    #1;
    if (obs_q.size() == 0) begin
      check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      e = obs_q.pop_front();
      check_eq({tag, "_cp"},  {11'd0, e[20:0]},  {11'd0, cp});
      check_eq({tag, "_err"}, {31'd0, e[24]},    {31'd0, err});
      check_eq({tag, "_len"}, {29'd0, e[23:21]}, {29'd0, len});
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
    end
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_sof    = 1'b0;
    out_ready = 1'b1;
    idle_cycles(3);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_cp",    {11'd0, out_cp},    32'd0);
    check_eq("rst_out_err",   {31'd0, out_err},   32'd0);
    check_eq("rst_out_len",   {29'd0, out_len},   32'd0);
    check_eq("rst_busy",      {31'd0, busy},      32'd0);
    check_eq("rst_err_count", {24'd0, err_count}, 32'd0);
    rst_n = 1'b1;
    idle_cycles(1);

    // T1: legal sequences of every length
    send_byte(8'h41, 1'b0);
    send_byte(8'hC3, 1'b0); send_byte(8'hA9, 1'b0);
    send_byte(8'hE2, 1'b0); send_byte(8'h82, 1'b0); send_byte(8'hAC, 1'b0);
    send_byte(8'hF0, 1'b0); send_byte(8'h9F, 1'b0); send_byte(8'h98, 1'b0); send_byte(8'h80, 1'b0);
    expect_cp("t1_a",     21'h000041, 1'b0, 3'd1);
    expect_cp("t1_e9",    21'h0000E9, 1'b0, 3'd2);
    expect_cp("t1_euro",  21'h0020AC, 1'b0, 3'd3);
    expect_cp("t1_emoji", 21'h01F600, 1'b0, 3'd4);
    check_eq("t1_err_count", {24'd0, err_count}, 32'd0);

    // T2: overlong E0 80, rejected byte re-decoded as a lead
    send_byte(8'hE0, 1'b0);
    check_eq("t2_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h80, 1'b0);
    send_byte(8'h41, 1'b0);
    expect_cp("t2_trunc", 21'h00FFFD, 1'b1, 3'd1);
    expect_cp("t2_stray", 21'h00FFFD, 1'b1, 3'd1);
    expect_cp("t2_a",     21'h000041, 1'b0, 3'd1);
    check_eq("t2_err_count", {24'd0, err_count}, 32'd2);

    // T3: surrogate ED A0 80
    send_byte(8'hED, 1'b0);
    send_byte(8'hA0, 1'b0);
    send_byte(8'h80, 1'b0);
    expect_cp("t3_trunc", 21'h00FFFD, 1'b1, 3'd1);
    expect_cp("t3_a0",    21'h00FFFD, 1'b1, 3'd1);
    expect_cp("t3_80",    21'h00FFFD, 1'b1, 3'd1);
    check_eq("t3_err_count", {24'd0, err_count}, 32'd5);

    // T4: in_sof mid-sequence discards the partial silently
    send_byte(8'hE2, 1'b0);
    send_byte(8'h82, 1'b0);
    check_eq("t4_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h41, 1'b1);
    expect_cp("t4_a", 21'h000041, 1'b0, 3'd1);
    idle_cycles(2);
    check_eq("t4_no_extra", obs_q.size(), 32'd0);
    check_eq("t4_err_count", {24'd0, err_count}, 32'd6);

    // T5: backpressure holds the output and stalls the input
    out_ready = 1'b0;
    send_byte(8'h41, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h42;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check_eq("t5_out_valid", {31'd0, out_valid}, 32'd1);
      check_eq("t5_out_cp",    {11'd0, out_cp},    32'h41);
      check_eq("t5_in_ready",  {31'd0, in_ready},  32'd0);
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    send_byte(8'h42, 1'b0);
    expect_cp("t5_a", 21'h000041, 1'b0, 3'd1);
    expect_cp("t5_b", 21'h000042, 1'b0, 3'd1);

    // T6: BOM at stream start
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hBF, 1'b0);
    send_byte(8'h41, 1'b0);
`ifndef UTF8_BOM_STRIP_EN
    expect_cp("t6_bom", 21'h00FEFF, 1'b0, 3'd3);
`endif
    expect_cp("t6_a", 21'h000041, 1'b0, 3'd1);
    idle_cycles(3);
    check_eq("end_no_extra",  obs_q.size(),       32'd0);
    check_eq("end_err_count", {24'd0, err_count}, 32'd6);
    check_eq("end_busy",      {31'd0, busy},      32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
